// File: rtl/sec_timer.sv
// sec_timer: seconds timer with prescaler, one-shot/periodic modes, pause and clear.
module sec_timer #(
  parameter int CLK_HZ = 100000000,
  parameter int SEC_W  = 4,
  parameter int PRE_W  = 27
) (
  input  logic             clk,
  input  logic             reseta,
  input  logic             start,
  input  logic             clear,
  input  logic             pause,
  input  logic             mode,
  input  logic [SEC_W-1:0] limit,
  output logic [SEC_W-1:0] timeout,
  output logic             tick,
  output logic             expired,
  output logic             running,
  output logic             done_reset
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state, state_n;
  logic [PRE_W-1:0] pre, pre_n;
  logic [SEC_W-1:0] lim_q, to_n, to_inc;
  logic mode_q, clear_q, cnt, wrap, hit, tick_n, exp_n;
  assign to_inc = timeout + SEC_W'(1);
  assign wrap   = pre == PRE_W'(CLK_HZ - 1);
  assign hit    = to_inc == lim_q;
  // PAUSED with pause released counts on that same edge, so a pause of N cycles delays by exactly N
  assign cnt    = (state == RUN || state == PAUSED) && !pause && !clear && !start;
  always_ff @(posedge clk) begin
    if (!reseta) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = clear ? IDLE
            : start ? (limit == '0 ? DONE : RUN)
            : (state == IDLE || state == DONE) ? state
            : pause ? PAUSED
            : (wrap && hit && !mode_q) ? DONE : RUN;
  end
  always_comb begin
    pre_n  = (clear || start) ? '0 : !cnt ? pre : wrap ? '0 : pre + PRE_W'(1);
    to_n   = (clear || start) ? '0 : !(cnt && wrap) ? timeout : (hit && mode_q) ? '0 : to_inc;
    tick_n = cnt && wrap;
    exp_n  = clear ? 1'b0 : start ? (limit == '0) : (cnt && wrap && hit);
  end
  always_ff @(posedge clk) begin
    if (!reseta) begin
      pre        <= '0;
      timeout    <= '0;
      tick       <= 1'b0;
      expired    <= 1'b0;
      running    <= 1'b0;
      done_reset <= 1'b1;
      clear_q    <= 1'b0;
      lim_q      <= '0;
      mode_q     <= 1'b0;
    end else begin
      pre        <= pre_n;
      timeout    <= to_n;
      tick       <= tick_n;
      expired    <= exp_n;
      running    <= state_n == RUN || state_n == PAUSED;
      done_reset <= clear && !clear_q;
      clear_q    <= clear;
      lim_q      <= (start && !clear) ? limit : lim_q;
      mode_q     <= (start && !clear) ? mode : mode_q;
    end
  end
endmodule

// File: tb/tb_sec_timer.sv
// tb_sec_timer: scoreboard bench; expectations come from an elapsed-cycle model of the timer.
module tb_sec_timer;
  localparam int HZ = 4, SW = 4, PW = 3;
  logic clk = 1'b0;
  logic reseta, start, clear, pause, mode;
  logic [SW-1:0] limit, timeout;
  logic tick, expired, running, done_reset;
  sec_timer #(.CLK_HZ(HZ), .SEC_W(SW), .PRE_W(PW)) dut (
    .clk(clk), .reseta(reseta), .start(start), .clear(clear), .pause(pause),
    .mode(mode), .limit(limit), .timeout(timeout), .tick(tick),
    .expired(expired), .running(running), .done_reset(done_reset)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [SW-1:0] to; logic tk, ex, rn, dr;} exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0, cyc = 0;
  int ec = 0, mlim = 0;
  bit act = 0, mmd = 0, pclr = 0, pz = 0;
  // Model: ec = counted cycles since start; seconds are ec/HZ, expiry at every multiple of limit seconds.
  task automatic step(input bit r, input bit c, input bit s, input bit p, input bit m, input int l);
    exp_t e;
    reseta = r; clear = c; start = s; pause = p; mode = m; limit = SW'(l);
    e = '0;
    if (!r) begin
      act = 0; ec = 0; mlim = 0; mmd = 0; e.dr = 1;
    end else if (c) begin
      act = 0; ec = 0; e.dr = !pclr;
    end else if (s) begin
      mlim = l; mmd = m; ec = 0; act = (l != 0); e.ex = (l == 0);
    end else if (act && !p) begin
      ec++;
      if (ec % HZ == 0) begin
        e.tk = 1;
        if ((ec / HZ) % mlim == 0) begin
          e.ex = 1;
          if (!mmd) act = 0;
        end
      end
    end
    pclr = r && c;
    e.to = SW'((mmd && mlim != 0) ? (ec / HZ) % mlim : ec / HZ);
    e.rn = act;
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic idle(input int n, input bit p);
    repeat (n) step(1, 0, 0, p, 1'($urandom), int'($urandom_range(0, 15)));
  endtask
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL cyc=%0d %s got %0d expected %0d", cyc, n, got, want);
    end
  endtask
  always @(posedge clk) begin
    #1;
    cyc++;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("timeout", int'(timeout), int'(me.to));
      chk("tick", int'(tick), int'(me.tk));
      chk("expired", int'(expired), int'(me.ex));
      chk("running", int'(running), int'(me.rn));
      chk("done_reset", int'(done_reset), int'(me.dr));
    end
  end
  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2, 0);
    step(1, 0, 1, 0, 0, 3);
    idle(16, 0);
    step(1, 0, 1, 0, 1, 2);
    idle(20, 0);
    step(1, 0, 1, 0, 0, 4);
    idle(2, 0);
    idle(10, 1);
    idle(8, 0);
    step(1, 0, 1, 0, 1, 0);
    idle(6, 0);
    step(1, 0, 1, 0, 0, 5);
    idle(9, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(3, 0);
    step(1, 0, 1, 0, 1, 3);
    idle(3, 0);
    step(1, 1, 1, 0, 1, 3);
    idle(2, 0);
    step(1, 0, 1, 0, 1, 2);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(2, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) pz = !pz;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 29) == 0, pz, 1'($urandom), int'($urandom_range(0, 4)));
    end
    idle(3, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sec_timer.md
SEC_TIMER -- requirements
Module: sec_timer

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 100000000, giving clock cycles per second (minimum 2).
REQ-002 The module SHALL have parameter SEC_W, default 4, giving the seconds counter and limit width.
REQ-003 The module SHALL have parameter PRE_W, default 27, giving the prescaler width, with 2^PRE_W >= CLK_HZ.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reseta, input, 1 bit, the reset: synchronous, active-low.
REQ-006 The module SHALL have port start, input, 1 bit, a one-cycle pulse that latches limit and mode, then runs from zero.
REQ-007 The module SHALL have port clear, input, 1 bit, a one-cycle pulse that aborts and returns to IDLE.
REQ-008 The module SHALL have port pause, input, 1 bit, a level that freezes counting while high in RUN.
REQ-009 The module SHALL have port mode, input, 1 bit: 0 selects one-shot, 1 selects periodic.
REQ-010 The module SHALL have port limit, input, SEC_W bits, the timeout length in seconds.
REQ-011 The module SHALL have port timeout, output, SEC_W bits, the elapsed whole seconds.
REQ-012 The module SHALL have port tick, output, 1 bit, a one-cycle pulse for each elapsed second.
REQ-013 The module SHALL have port expired, output, 1 bit, a one-cycle pulse when elapsed seconds reach the latched limit.
REQ-014 The module SHALL have port running, output, 1 bit, high in RUN and PAUSED.
REQ-015 The module SHALL have port done_reset, output, 1 bit, high for one cycle after a reset or clear takes effect.

Function
REQ-016 The module SHALL implement states IDLE, RUN, PAUSED and DONE; all outputs SHALL be registered.
REQ-017 Input priority SHALL be reset > clear > start > pause.
REQ-018 start SHALL clear the prescaler and timeout and latch limit and mode; the next state SHALL be RUN, or DONE if the latched limit is 0.
REQ-019 start with limit 0 SHALL assert expired in the next cycle in both modes.
REQ-020 start while in RUN, PAUSED or DONE SHALL restart identically to start from IDLE.
REQ-021 In RUN with pause low, the prescaler SHALL count 0..CLK_HZ-1 and wrap to 0.
REQ-022 On the edge where the prescaler equals CLK_HZ-1 in RUN, timeout SHALL become timeout+1 and tick SHALL be 1 in the following cycle.
REQ-023 When that increment makes timeout equal the latched limit, expired SHALL pulse in the same cycle as tick.
REQ-024 In one-shot mode at expiry, the next state SHALL be DONE and timeout SHALL hold the limit value.
REQ-025 In periodic mode at expiry, timeout SHALL load 0 (not the limit), the state SHALL stay RUN, and the prescaler SHALL continue without a gap.
REQ-026 pause high in RUN SHALL move to PAUSED and hold the prescaler and timeout.
REQ-027 pause low in PAUSED SHALL return to RUN and resume from the held prescaler value.
REQ-028 pause SHALL be ignored in IDLE and DONE.
REQ-029 In PAUSED, tick and expired SHALL stay low.
REQ-030 clear SHALL set the state to IDLE and zero the prescaler and timeout.
REQ-031 clear SHALL drive done_reset to 1 for exactly one cycle, even when asserted repeatedly.
REQ-032 Changes to limit or mode after start SHALL have no effect until the next start.
REQ-033 timeout SHALL never exceed the latched limit and SHALL never wrap past 2^SEC_W-1.

Reset
REQ-034 With reseta low at a clock edge, the state SHALL be IDLE and prescaler, timeout, tick, expired and running SHALL be 0.
REQ-035 With reseta low, done_reset SHALL be 1.
REQ-036 On the first edge with reseta high and no clear, done_reset SHALL return to 0.
REQ-037 Reset mid-RUN SHALL discard all progress; no tick or expired SHALL issue after reset.
REQ-038 Before the first reset, outputs SHALL be undefined; the bench SHALL apply reset first.

Verification
REQ-039 CLK_HZ=4, mode 0, limit 3, start: tick at cycles 4, 8 and 12 after start; expired with the third tick; timeout=3 and running=0 afterwards.
REQ-040 CLK_HZ=4, mode 1, limit 2: expired every 8 cycles; timeout sequence 1, 0 (at expiry), 1, 0; running stays 1.
REQ-041 pause held high 10 cycles mid-second: tick delayed exactly 10 cycles; timeout frozen throughout.
REQ-042 start with limit 0: expired=1 the next cycle; state DONE; no tick.
REQ-043 reseta low mid-RUN at timeout=2: the next cycle shows timeout=0, done_reset=1, running=0.
REQ-044 clear and start in the same cycle: IDLE, done_reset=1, running=0.
